// File: rtl/io_input_port_if.sv
// ----------------------------------------------------------------------------
// io_input_port_if : external pins, bus strobes and status flags of io_input_port
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface io_input_port_if;
  logic [15:0] external_IN0_input;
  logic        bus_IN0_output_en;
  logic        bus_IN0_status_en;
  logic        bus_IN0_ack;
  logic        IN0_ready;
  logic        IN0_overrun;

  modport master (
    output external_IN0_input,
    output bus_IN0_output_en,
    output bus_IN0_status_en,
    output bus_IN0_ack,
    input  IN0_ready,
    input  IN0_overrun
  );

  modport slave (
    input  external_IN0_input,
    input  bus_IN0_output_en,
    input  bus_IN0_status_en,
    input  bus_IN0_ack,
    output IN0_ready,
    output IN0_overrun
  );
endinterface

`default_nettype wire

// File: rtl/io_input_port.sv
// ----------------------------------------------------------------------------
// io_input_port : synchronised, debounced 16-bit input port with tri-state bus read
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module io_input_port #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  wire logic        IN0_clock,
  input  wire logic        IN0_reset,
  io_input_port_if.slave   port,
  output wire       [15:0] bus_IN0_output
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_t;

  state_t            state;
  logic [15:0]       sync1;
  logic [15:0]       sync2;
  logic [15:0]       candidate;
  logic [15:0]       data;
  logic [CNT_W-1:0]  count;
  logic              ready;
  logic              overrun;
  logic              capture;
  logic              bus_en;
  logic [15:0]       bus_word;

  // A settled candidate equal to the held value is a bounce, not a capture.
  always_comb begin
    capture = (state == SETTLE) && (sync2 == candidate) &&
              (count == LAST) && (candidate != data);
  end

  always_ff @(posedge IN0_clock) begin
    if (IN0_reset) begin
      sync1     <= '0;
      sync2     <= '0;
      candidate <= '0;
      data      <= '0;
      count     <= '0;
      ready     <= 1'b0;
      overrun   <= 1'b0;
      state     <= IDLE;
    end else begin
      sync1 <= port.external_IN0_input;
      sync2 <= sync1;

      case (state)
        IDLE: begin
          if (sync2 != candidate) begin
            candidate <= sync2;
            count     <= '0;
            state     <= SETTLE;
          end
        end
        SETTLE: begin
          if (sync2 != candidate) begin
            candidate <= sync2;
            count     <= '0;
          end else if (count == LAST) begin
            state <= IDLE;
            if (capture) begin
              data <= candidate;
            end
          end else begin
            count <= count + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // An ack on the capture edge consumes the previous value, so no overrun.
      if (capture) begin
        ready   <= 1'b1;
        overrun <= port.bus_IN0_ack ? 1'b0 : (overrun | ready);
      end else if (port.bus_IN0_ack) begin
        ready   <= 1'b0;
        overrun <= 1'b0;
      end
    end
  end

  assign port.IN0_ready   = ready;
  assign port.IN0_overrun = overrun;

  assign bus_en   = port.bus_IN0_output_en | port.bus_IN0_status_en;
  assign bus_word = port.bus_IN0_status_en ? {14'b0, overrun, ready} : data;

  assign bus_IN0_output = bus_en ? bus_word : 16'hzzzz;

endmodule

`default_nettype wire

// File: tb/tb_io_input_port.sv
// ----------------------------------------------------------------------------
// tb_io_input_port : directed vector table plus hand sequences for io_input_port
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_io_input_port;

  localparam logic [15:0] RELEASED = 16'hFFFF;  // value seen via the pull-up when undriven

  logic       clk;
  logic       rst;
  tri  [15:0] bus_out;
  int         checks;
  int         errors;

  io_input_port_if bus_if ();

  pullup (bus_out);

  io_input_port #(
    .STABLE_CYCLES (4),
    .CNT_W         (8)
  ) dut (
    .IN0_clock      (clk),
    .IN0_reset      (rst),
    .port           (bus_if.slave),
    .bus_IN0_output (bus_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ext;
    logic        oe;
    logic        se;
    logic        ack;
    int          hold;
    logic        rdy;
    logic        ovr;
    logic [15:0] bus;
  } vec_t;

  vec_t vecs [0:12];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic read_bus(input logic oe, input logic se, input logic [15:0] exp, input string nm);
    bus_if.bus_IN0_output_en = oe;
    bus_if.bus_IN0_status_en = se;
    #1;
    chk(nm, bus_out, exp);
    bus_if.bus_IN0_output_en = 1'b0;
    bus_if.bus_IN0_status_en = 1'b0;
  endtask

  task automatic ack_pulse();
    bus_if.bus_IN0_ack = 1'b1;
    @(negedge clk);
    bus_if.bus_IN0_ack = 1'b0;
    #1;
  endtask

  task automatic edges_check_ready(input int n, input int rise_at, input string nm);
    for (int j = 1; j <= n; j++) begin
      @(negedge clk);
      #1;
      chk($sformatf("%s_edge%0d_ready", nm, j), {15'b0, bus_if.IN0_ready},
          {15'b0, (j >= rise_at)});
    end
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      bus_if.external_IN0_input = vecs[i].ext;
      bus_if.bus_IN0_output_en  = vecs[i].oe;
      bus_if.bus_IN0_status_en  = vecs[i].se;
      bus_if.bus_IN0_ack        = vecs[i].ack;
      for (int c = 0; c < vecs[i].hold; c++) begin
        @(negedge clk);
        bus_if.bus_IN0_ack = 1'b0;
      end
      #1;
      chk($sformatf("vec%0d_ready", i), {15'b0, bus_if.IN0_ready}, {15'b0, vecs[i].rdy});
      chk($sformatf("vec%0d_overrun", i), {15'b0, bus_if.IN0_overrun}, {15'b0, vecs[i].ovr});
      chk($sformatf("vec%0d_bus", i), bus_out, vecs[i].bus);
    end
    bus_if.bus_IN0_output_en = 1'b0;
    bus_if.bus_IN0_status_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    //          ext       oe    se    ack   hold rdy   ovr   bus
    vecs[0]  = '{16'h0000, 1'b0, 1'b0, 1'b0, 20, 1'b0, 1'b0, RELEASED};
    vecs[1]  = '{16'h0000, 1'b1, 1'b0, 1'b0, 1,  1'b0, 1'b0, 16'h0000};
    vecs[2]  = '{16'h0000, 1'b0, 1'b1, 1'b0, 1,  1'b0, 1'b0, 16'h0000};
    vecs[3]  = '{16'h1111, 1'b0, 1'b0, 1'b0, 10, 1'b1, 1'b0, RELEASED};
    vecs[4]  = '{16'h2222, 1'b0, 1'b0, 1'b0, 10, 1'b1, 1'b1, RELEASED};
    vecs[5]  = '{16'h2222, 1'b1, 1'b0, 1'b0, 1,  1'b1, 1'b1, 16'h2222};
    vecs[6]  = '{16'h2222, 1'b0, 1'b1, 1'b0, 1,  1'b1, 1'b1, 16'h0003};
    vecs[7]  = '{16'h2222, 1'b1, 1'b1, 1'b0, 1,  1'b1, 1'b1, 16'h0003};
    vecs[8]  = '{16'h2222, 1'b0, 1'b1, 1'b1, 1,  1'b0, 1'b0, 16'h0000};
    vecs[9]  = '{16'h2222, 1'b0, 1'b1, 1'b1, 2,  1'b0, 1'b0, 16'h0000};
    vecs[10] = '{16'h2222, 1'b1, 1'b0, 1'b0, 5,  1'b0, 1'b0, 16'h2222};
    vecs[11] = '{16'h0000, 1'b0, 1'b1, 1'b0, 10, 1'b1, 1'b0, 16'h0001};
    vecs[12] = '{16'h0000, 1'b1, 1'b0, 1'b1, 1,  1'b0, 1'b0, 16'h0000};

    rst = 1'b1;
    bus_if.external_IN0_input = 16'h0000;
    bus_if.bus_IN0_output_en  = 1'b0;
    bus_if.bus_IN0_status_en  = 1'b0;
    bus_if.bus_IN0_ack        = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_ready", {15'b0, bus_if.IN0_ready}, 16'h0000);
    chk("reset_overrun", {15'b0, bus_if.IN0_overrun}, 16'h0000);
    chk("reset_bus_released", bus_out, RELEASED);
    read_bus(1'b1, 1'b0, 16'h0000, "reset_data");

    // Idle input, bus release and plain reads
    run_vecs(0, 2);

    // First capture lands exactly on edge 7 with STABLE_CYCLES = 4
    bus_if.external_IN0_input = 16'hA5A5;
    edges_check_ready(7, 7, "a5a5");
    chk("a5a5_overrun", {15'b0, bus_if.IN0_overrun}, 16'h0000);
    read_bus(1'b1, 1'b0, 16'hA5A5, "a5a5_data");
    ack_pulse();
    chk("a5a5_ack_ready", {15'b0, bus_if.IN0_ready}, 16'h0000);
    read_bus(1'b1, 1'b0, 16'hA5A5, "a5a5_data_held");

    // Overrun, status word, ack clearing, idle ack, re-read
    run_vecs(3, 12);

    // Bounce 00FF -> 0000 -> 00FF: only the final stable value is captured
    bus_if.external_IN0_input = 16'h00FF;
    edges_check_ready(2, 99, "bounce_hi");
    bus_if.external_IN0_input = 16'h0000;
    edges_check_ready(2, 99, "bounce_lo");
    bus_if.external_IN0_input = 16'h00FF;
    edges_check_ready(7, 7, "bounce_final");
    read_bus(1'b1, 1'b0, 16'h00FF, "bounce_data");

    // Ack on the capture edge: ready stays set and no overrun is recorded
    bus_if.external_IN0_input = 16'h0F0F;
    repeat (6) @(negedge clk);
    read_bus(1'b1, 1'b0, 16'h00FF, "ackcap_before");
    bus_if.bus_IN0_ack = 1'b1;
    @(negedge clk);
    bus_if.bus_IN0_ack = 1'b0;
    #1;
    chk("ackcap_ready", {15'b0, bus_if.IN0_ready}, 16'h0001);
    chk("ackcap_overrun", {15'b0, bus_if.IN0_overrun}, 16'h0000);
    read_bus(1'b1, 1'b0, 16'h0F0F, "ackcap_data");

    // Reset mid-settle aborts the count; the input is re-captured from scratch
    ack_pulse();
    bus_if.external_IN0_input = 16'hF00D;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_ready", {15'b0, bus_if.IN0_ready}, 16'h0000);
    chk("midrst_overrun", {15'b0, bus_if.IN0_overrun}, 16'h0000);
    read_bus(1'b1, 1'b0, 16'h0000, "midrst_data");
    read_bus(1'b0, 1'b1, 16'h0000, "midrst_status");
    edges_check_ready(7, 7, "recap");
    read_bus(1'b1, 1'b0, 16'hF00D, "recap_data");
    read_bus(1'b0, 1'b0, RELEASED, "final_released");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
